// File: rtl/bus_share_arbiter.sv
// -----------------------------------------------------------------------------
// bus_share_arbiter
//   Shares one WIDTH-bit 2:1 mux datapath between two packet-streaming
//   requesters. The grant is round-robin at packet granularity. An owner keeps
//   the grant until its packet ends or MAX_BEATS beats have been taken. The
//   selected beat is captured into a single output register stage.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   req{0,1}_valid/data/last   requester beat stream
//   req{0,1}_ready             beat accepted when valid & ready
//   out_valid/data/last        registered output beat
//   out_ready                  downstream accepts when out_valid & out_ready
//   mux_sel                    0 selects requester 0, 1 selects requester 1
//   busy                       a requester currently holds the grant
// -----------------------------------------------------------------------------
module bus_share_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             mux_sel,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             sel1;
  logic             slot_free;
  logic             own_valid;
  logic [WIDTH-1:0] own_data;
  logic             own_last;
  logic             accept;

  assign sel1      = (state_q == OWN1);
  // The output stage can take a beat if it is empty or draining this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign own_valid = sel1 ? req1_valid : req0_valid;
  assign own_data  = sel1 ? req1_data  : req0_data;
  assign own_last  = sel1 ? req1_last  : req0_last;
  assign accept    = (state_q != IDLE) && own_valid && slot_free;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        // Arbitration takes a full cycle; no beat moves while idle.
        if (req0_valid && req1_valid) begin
          state_d = prio_q ? OWN1 : OWN0;
        end else if (req0_valid) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          // Release on packet end or when the tenure beat budget is spent;
          // the other requester gets priority for the next contest.
          if (own_last || (cnt_q == LAST_CNT)) begin
            state_d = IDLE;
            cnt_d   = '0;
            prio_d  = !sel1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = own_data;
      out_last_d  = own_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign req0_ready = (state_q == OWN0) && slot_free;
  assign req1_ready = (state_q == OWN1) && slot_free;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign mux_sel    = sel1;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bus_share_arbiter.sv
module tb_bus_share_arbiter;

  localparam int W     = 16;
  localparam int MB    = 8;
  localparam int LIMIT = 2000;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_last, req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] req1_data;
  logic         out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  logic         mux_sel, busy;

  bus_share_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .mux_sel(mux_sel), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t sb[$];
  beat_t p0[$];
  beat_t p1[$];
  bit    f0[$];
  bit    f1[$];
  int    checks = 0;
  int    errors = 0;
  bit    model_prio;

  logic [W-1:0] hold_d;
  logic         hold_l;
  bit           hold_vld = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_pkts();
    p0.delete();
    p1.delete();
  endtask

  task automatic add_pkt(input int who, input int len, input logic [W-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + W'(k);
      b.l = (k == len - 1);
      if (who == 0) p0.push_back(b);
      else          p1.push_back(b);
    end
  endtask

  // Reference: replay the grant tenures at packet level. A tenure goes to the
  // only requester with data, or to the priority holder when both have data;
  // it lasts until a last beat or MB beats. Also marks each tenure's first beat
  // so the driver keeps that beat's valid steady while it contends.
  task automatic build_model();
    int a, b, cnt;
    bit own, p, lst, done;
    f0.delete();
    f1.delete();
    foreach (p0[k]) f0.push_back(1'b0);
    foreach (p1[k]) f1.push_back(1'b0);
    p = model_prio;
    a = 0;
    b = 0;
    lst = 0;
    while (a < p0.size() || b < p1.size()) begin
      if (a < p0.size() && b < p1.size()) own = p;
      else own = (a < p0.size()) ? 1'b0 : 1'b1;
      cnt = 0;
      done = 0;
      while (!done) begin
        if (!own) begin
          if (a >= p0.size()) break;
          if (cnt == 0) f0[a] = 1'b1;
          sb.push_back(p0[a]);
          lst = p0[a].l;
          a++;
        end else begin
          if (b >= p1.size()) break;
          if (cnt == 0) f1[b] = 1'b1;
          sb.push_back(p1[b]);
          lst = p1[b].l;
          b++;
        end
        cnt++;
        done = lst || (cnt == MB);
      end
      p = !own;
    end
    model_prio = p;
  endtask

  task automatic run_round(input bit do_reset, input int gap_pct, input int ready_mode);
    int i0, i1, cyc;
    bit a0, a1;
    if (do_reset) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_prio = 1'b0;
    end
    build_model();
    i0 = 0;
    i1 = 0;
    cyc = 0;
    while ((i0 < p0.size() || i1 < p1.size() || sb.size() != 0) && cyc < LIMIT) begin
      req0_valid = (i0 < p0.size()) && (f0[i0] || int'($urandom_range(99)) >= gap_pct);
      req1_valid = (i1 < p1.size()) && (f1[i1] || int'($urandom_range(99)) >= gap_pct);
      if (i0 < p0.size()) begin
        req0_data = p0[i0].d;
        req0_last = p0[i0].l;
      end else begin
        req0_data = W'($urandom);
        req0_last = 1'b0;
      end
      if (i1 < p1.size()) begin
        req1_data = p1[i1].d;
        req1_last = p1[i1].l;
      end else begin
        req1_data = W'($urandom);
        req1_last = 1'b0;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = !(cyc >= 4 && cyc < 7);
      endcase
      @(negedge clock);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) chk("mux_sel_on_req0_accept", mux_sel, 0);
      if (a1) chk("mux_sel_on_req1_accept", mux_sel, 1);
      step();
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    checks++;
    if (cyc >= LIMIT) begin
      errors++;
      $display("FAIL round_timeout: %0d cycles, pending beats sb=%0d req0=%0d req1=%0d, required completion",
               cyc, sb.size(), p0.size() - i0, p1.size() - i1);
    end
  endtask

  // Monitor: checks every output transfer against the scoreboard and the
  // back-pressure rules, independently of the stimulus processes.
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_vld = 0;
      end else begin
        checks++;
        if (req0_ready && req1_ready) begin
          errors++;
          $display("FAIL ready_exclusive: req0_ready=%b req1_ready=%b, required at most one", req0_ready, req1_ready);
        end
        if (out_valid && !out_ready) begin
          checks++;
          if (req0_ready || req1_ready) begin
            errors++;
            $display("FAIL backpressure_ready: req0_ready=%b req1_ready=%b, required 0/0", req0_ready, req1_ready);
          end
          if (hold_vld) begin
            checks++;
            if (out_data !== hold_d || out_last !== hold_l) begin
              errors++;
              $display("FAIL backpressure_hold: data=%h last=%b, required data=%h last=%b", out_data, out_last, hold_d, hold_l);
            end
          end
          hold_vld = 1;
          hold_d = out_data;
          hold_l = out_last;
        end else begin
          hold_vld = 0;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: data=%h last=%b, required no beat", out_data, out_last);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
              errors++;
              $display("FAIL out_beat: data=%h last=%b, required data=%h last=%b", out_data, out_last, e.d, e.l);
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    out_ready  = 1'b1;
    model_prio = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);

    // Single beat latency
    reset = 1'b0;
    step();
    req0_valid = 1'b1; req0_data = 16'h1234; req0_last = 1'b1;
    sb.push_back('{16'h1234, 1'b1});
    chk("t1_c0_busy", busy, 0);
    chk("t1_c0_ready", req0_ready, 0);
    step();
    chk("t1_c1_ready", req0_ready, 1);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_mux_sel", mux_sel, 0);
    step();
    req0_valid = 1'b0;
    chk("t1_c2_out_valid", out_valid, 1);
    chk("t1_c2_out_data", out_data, 32'h1234);
    chk("t1_c2_out_last", out_last, 1);
    chk("t1_c2_busy", busy, 0);
    step();
    chk("t1_c3_out_valid", out_valid, 0);

    // Both requesters from reset, then priority check
    clear_pkts(); add_pkt(0, 2, 16'hA000); add_pkt(1, 2, 16'hB000);
    run_round(1, 0, 0);
    clear_pkts(); add_pkt(0, 1, 16'hC000); add_pkt(1, 1, 16'hD000);
    run_round(0, 0, 0);

    // Forced release at the beat limit
    clear_pkts(); add_pkt(0, 10, 16'h3000); add_pkt(1, 2, 16'h4000);
    run_round(1, 0, 0);

    // Output stall mid-packet
    clear_pkts(); add_pkt(0, 6, 16'h7000);
    run_round(1, 0, 2);

    // Reset mid-packet
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_prio = 1'b0;
    sb.delete();
    req0_valid = 1'b1; req0_data = 16'h5000; req0_last = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("t5_pre_out_valid", out_valid, 1);
    chk("t5_pre_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_out_data", out_data, 0);
    chk("t5_async_mux_sel", mux_sel, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_req0_ready", req0_ready, 0);
    step();
    reset = 1'b0;
    clear_pkts(); add_pkt(0, 1, 16'h5100); add_pkt(1, 1, 16'h6100);
    req0_valid = 1'b1; req0_data = 16'h5100; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 16'h6100; req1_last = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t5_fresh_mux_sel", mux_sel, 0);
    chk("t5_fresh_busy", busy, 1);
    run_round(0, 0, 0);

    // req1 alone, then contention goes to req0
    clear_pkts(); add_pkt(1, 4, 16'h9000);
    run_round(1, 0, 0);
    clear_pkts(); add_pkt(0, 1, 16'h9100); add_pkt(1, 1, 16'h9200);
    run_round(0, 0, 0);

    // Randomized traffic with valid gaps and random back-pressure
    for (int r = 0; r < 8; r++) begin
      clear_pkts();
      for (int w = 0; w < 2; w++) begin
        int np;
        np = int'($urandom_range(4));
        for (int k = 0; k < np; k++) begin
          add_pkt(w, int'($urandom_range(12, 1)), W'($urandom));
        end
      end
      run_round((r % 2) == 0, 30, 1);
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
